// File: rtl/countdown_timer_if.sv
// Command/status bundle for countdown_timer.
// Latency: wires only; no storage in the interface.
// Backpressure: none; commands are single-cycle strobes sampled every clk edge.
//
// Ports (master = controller side, slave = timer side):
//   tick, load, start, pause, clear     one-cycle command strobes
//   load_hr/load_min/load_sec           value presented with load
//   hr_counter/min_counter/sec_counter  remaining time (registered)
//   running, expired, load_err          status (registered)
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       pause;
    logic       clear;
    logic [4:0] hr_counter;
    logic [5:0] min_counter;
    logic [5:0] sec_counter;
    logic       running;
    logic       expired;
    logic       load_err;

    modport master (
        output tick, load, load_hr, load_min, load_sec, start, pause, clear,
        input  hr_counter, min_counter, sec_counter, running, expired, load_err
    );

    modport slave (
        input  tick, load, load_hr, load_min, load_sec, start, pause, clear,
        output hr_counter, min_counter, sec_counter, running, expired, load_err
    );
endinterface

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with load/start/pause/clear control and 1 Hz tick.
// Latency: every accepted command shows on the registered outputs one cycle later.
// Backpressure: none; commands never stall, illegal loads are dropped with a load_err pulse.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   tif   countdown_timer_if.slave: command strobes, load fields, counters and status
module countdown_timer #(
    parameter int HR_MAX = 23
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   tif
);

    localparam logic [4:0] HR_LIM = 5'(HR_MAX);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] hr_q, hr_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       running_q, expired_q, load_err_q;
    logic       load_err_d;

    logic load_ok;
    logic load_zero;
    logic cnt_zero;

    assign load_ok   = (tif.load_hr <= HR_LIM) && (tif.load_min <= 6'd59) &&
                       (tif.load_sec <= 6'd59);
    assign load_zero = (tif.load_hr == 5'd0) && (tif.load_min == 6'd0) &&
                       (tif.load_sec == 6'd0);
    assign cnt_zero  = (hr_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);

    always_comb begin
        state_d    = state_q;
        hr_d       = hr_q;
        min_d      = min_q;
        sec_d      = sec_q;
        load_err_d = 1'b0;

        if (tif.clear) begin
            state_d = IDLE;
            hr_d    = 5'd0;
            min_d   = 6'd0;
            sec_d   = 6'd0;
        end else if (tif.load) begin
            if ((state_q == RUN) || !load_ok) begin
                load_err_d = 1'b1;
                // A rejected load does not hold EXPIRED open; the pulse stays one cycle.
                if (state_q == EXPIRED) begin
                    state_d = IDLE;
                end
            end else begin
                hr_d    = tif.load_hr;
                min_d   = tif.load_min;
                sec_d   = tif.load_sec;
                state_d = load_zero ? IDLE : ARMED;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                ARMED, PAUSED: begin
                    // pause outranks start, so a simultaneous pause swallows the start.
                    // A tick here is ignored: the first decrement waits for RUN.
                    if (!tif.pause && tif.start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tif.pause) begin
                        state_d = PAUSED;
                    end else if (tif.tick && !cnt_zero) begin
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else begin
                            sec_d = 6'd59;
                            if (min_q != 6'd0) begin
                                min_d = min_q - 6'd1;
                            end else begin
                                min_d = 6'd59;
                                hr_d  = hr_q - 5'd1;
                            end
                        end
                        if ((hr_d == 5'd0) && (min_d == 6'd0) && (sec_d == 6'd0)) begin
                            state_d = EXPIRED;
                        end
                    end
                end
                EXPIRED: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hr_q       <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            // Status flops track the next state so they line up with the state register.
            running_q  <= (state_d == RUN);
            expired_q  <= (state_d == EXPIRED);
            load_err_q <= load_err_d;
        end
    end

    assign tif.hr_counter  = hr_q;
    assign tif.min_counter = min_q;
    assign tif.sec_counter = sec_q;
    assign tif.running     = running_q;
    assign tif.expired     = expired_q;
    assign tif.load_err    = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: stimulus pushes expected outputs into a
// queue tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_bad;

    countdown_timer_if tif ();

    countdown_timer #(.HR_MAX(23)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif.slave)
    );

    typedef struct {
        string      name;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       r;
        logic       e;
        logic       le;
        int         due;
    } exp_t;

    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [4:0] h, input logic [5:0] m,
                       input logic [5:0] s, input logic r, input logic e, input logic le);
        n_vec++;
        if (tif.hr_counter !== h || tif.min_counter !== m || tif.sec_counter !== s ||
            tif.running !== r || tif.expired !== e || tif.load_err !== le) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d run=%b exp=%b err=%b, want %0d:%0d:%0d run=%b exp=%b err=%b",
                     nm, tif.hr_counter, tif.min_counter, tif.sec_counter, tif.running,
                     tif.expired, tif.load_err, h, m, s, r, e, le);
        end
    endtask

    // Monitor: outputs are stable at negedge; compare every entry that has come due.
    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            if (x.due < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: compared late at cycle %0d, want cycle %0d", x.name, cyc, x.due);
            end else begin
                chk(x.name, x.h, x.m, x.s, x.r, x.e, x.le);
            end
        end
    end

    // Commands are already driven at this negedge; expect the result after the next posedge.
    task automatic step(input string nm, input int h, input int m, input int s,
                        input bit r, input bit e, input bit le);
        exp_t x;
        x.name = nm;
        x.h    = 5'(h);
        x.m    = 6'(m);
        x.s    = 6'(s);
        x.r    = r;
        x.e    = e;
        x.le   = le;
        x.due  = cyc + 1;
        q.push_back(x);
        @(negedge clk);
        tif.tick  = 1'b0;
        tif.load  = 1'b0;
        tif.start = 1'b0;
        tif.pause = 1'b0;
        tif.clear = 1'b0;
    endtask

    task automatic set_load(input int h, input int m, input int s);
        tif.load     = 1'b1;
        tif.load_hr  = 5'(h);
        tif.load_min = 6'(m);
        tif.load_sec = 6'(s);
    endtask

    initial begin
        cyc      = 0;
        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        tif.tick = 1'b0;
        tif.load = 1'b0;
        tif.start = 1'b0;
        tif.pause = 1'b0;
        tif.clear = 1'b0;
        tif.load_hr  = 5'd0;
        tif.load_min = 6'd0;
        tif.load_sec = 6'd0;

        #1;
        chk("reset_t0", 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_hold", 0, 0, 0, 0, 0, 0);

        // Release reset with a load already presented: the first edge must act on it.
        rst = 1'b1;
        set_load(0, 0, 3);
        step("a_load_first_edge", 0, 0, 3, 0, 0, 0);
        tif.start = 1'b1; tif.tick = 1'b1;
        step("a_start_tick_no_dec", 0, 0, 3, 1, 0, 0);
        tif.tick = 1'b1;
        step("a_tick1", 0, 0, 2, 1, 0, 0);
        step("a_no_tick", 0, 0, 2, 1, 0, 0);
        tif.tick = 1'b1;
        step("a_tick2", 0, 0, 1, 1, 0, 0);
        tif.tick = 1'b1;
        step("a_tick3_expired", 0, 0, 0, 0, 1, 0);
        step("a_back_idle", 0, 0, 0, 0, 0, 0);
        tif.start = 1'b1;
        step("a_start_in_idle", 0, 0, 0, 0, 0, 0);

        set_load(1, 0, 0);
        step("b_load", 1, 0, 0, 0, 0, 0);
        tif.start = 1'b1;
        step("b_start", 1, 0, 0, 1, 0, 0);
        tif.tick = 1'b1;
        step("b_hour_borrow", 0, 59, 59, 1, 0, 0);
        tif.tick = 1'b1;
        step("b_tick2", 0, 59, 58, 1, 0, 0);
        set_load(0, 0, 5); tif.tick = 1'b1;
        step("b_load_in_run", 0, 59, 58, 1, 0, 1);
        tif.tick = 1'b1;
        step("b_tick3", 0, 59, 57, 1, 0, 0);
        tif.clear = 1'b1;
        step("b_clear", 0, 0, 0, 0, 0, 0);

        set_load(0, 0, 60);
        step("c_sec60_rejected", 0, 0, 0, 0, 0, 1);
        step("c_err_one_cycle", 0, 0, 0, 0, 0, 0);
        set_load(24, 0, 0);
        step("c_hr24_rejected", 0, 0, 0, 0, 0, 1);
        set_load(0, 60, 0);
        step("c_min60_rejected", 0, 0, 0, 0, 0, 1);
        set_load(23, 59, 59);
        step("c_load_max", 23, 59, 59, 0, 0, 0);
        tif.start = 1'b1;
        step("c_start_max", 23, 59, 59, 1, 0, 0);
        tif.tick = 1'b1;
        step("c_dec_max", 23, 59, 58, 1, 0, 0);
        tif.clear = 1'b1;
        step("c_clear", 0, 0, 0, 0, 0, 0);
        set_load(0, 0, 7);
        step("c_load7", 0, 0, 7, 0, 0, 0);
        set_load(0, 0, 0);
        step("c_load_zero", 0, 0, 0, 0, 0, 0);
        tif.start = 1'b1;
        step("c_start_after_zero", 0, 0, 0, 0, 0, 0);

        set_load(0, 0, 5);
        step("d_load", 0, 0, 5, 0, 0, 0);
        tif.start = 1'b1;
        step("d_start", 0, 0, 5, 1, 0, 0);
        tif.pause = 1'b1; tif.tick = 1'b1;
        step("d_pause_with_tick", 0, 0, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tif.tick = 1'b1;
            step("d_tick_while_paused", 0, 0, 5, 0, 0, 0);
        end
        tif.start = 1'b1;
        step("d_resume", 0, 0, 5, 1, 0, 0);
        tif.tick = 1'b1;
        step("d_tick_after_resume", 0, 0, 4, 1, 0, 0);
        tif.clear = 1'b1;
        step("d_clear", 0, 0, 0, 0, 0, 0);

        set_load(0, 10, 0);
        step("e_load", 0, 10, 0, 0, 0, 0);
        tif.start = 1'b1;
        step("e_start", 0, 10, 0, 1, 0, 0);
        tif.clear = 1'b1; set_load(0, 0, 60); tif.start = 1'b1; tif.tick = 1'b1;
        step("e_clear_wins", 0, 0, 0, 0, 0, 0);
        step("e_idle_quiet", 0, 0, 0, 0, 0, 0);

        set_load(0, 0, 1);
        step("f_load", 0, 0, 1, 0, 0, 0);
        tif.start = 1'b1;
        step("f_start", 0, 0, 1, 1, 0, 0);
        // Assert reset between edges with a tick pending that would otherwise expire it.
        tif.tick = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("f_rst_async", 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("f_rst_hold", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tif.tick = 1'b0;
        step("f_no_expired_after_rst", 0, 0, 0, 0, 0, 0);
        tif.tick = 1'b1;
        step("f_idle_after_rst", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter HR_MAX, default 23, SHALL set the largest legal hour value; it is the only parameter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-low (0 = reset).
REQ-004 tick  input  1  SHALL be a one-cycle 1 Hz enable; each high cycle is one elapsed second.
REQ-005 load  input  1  SHALL request loading load_hr/load_min/load_sec into the counters.
REQ-006 load_hr  input  5  SHALL be the hour value to load (0..HR_MAX legal).
REQ-007 load_min  input  6  SHALL be the minute value to load (0..59 legal).
REQ-008 load_sec  input  6  SHALL be the second value to load (0..59 legal).
REQ-009 start  input  1  SHALL request entry to counting.
REQ-010 pause  input  1  SHALL request suspension of counting.
REQ-011 clear  input  1  SHALL request synchronous return to zero/idle.
REQ-012 hr_counter  output  5  SHALL be the registered remaining hours.
REQ-013 min_counter  output  6  SHALL be the registered remaining minutes.
REQ-014 sec_counter  output  6  SHALL be the registered remaining seconds.
REQ-015 running  output  1  SHALL be high exactly while the state is RUN.
REQ-016 expired  output  1  SHALL be a one-cycle pulse marking countdown completion.
REQ-017 load_err  output  1  SHALL be a one-cycle pulse marking a rejected load.

Function
REQ-018 The FSM SHALL have states IDLE (counters zero), ARMED (nonzero, stopped), RUN, PAUSED, EXPIRED.
REQ-019 Per-cycle command priority SHALL be clear > load > pause > start; lower-priority commands in the same cycle are ignored.
REQ-020 clear in any state SHALL zero all counters and enter IDLE at the next edge; no pulse output asserts.
REQ-021 load in IDLE, ARMED, PAUSED or EXPIRED with all fields legal SHALL write the fields at the next edge and enter ARMED, or IDLE if all fields are zero.
REQ-022 load with any field out of range, or load while in RUN, SHALL leave counters and state unchanged and pulse load_err for the following cycle.
REQ-023 start in ARMED or PAUSED SHALL enter RUN at the next edge; start in IDLE, RUN or EXPIRED SHALL be ignored.
REQ-024 pause in RUN SHALL enter PAUSED at the next edge with no decrement, even if tick is high that cycle; pause elsewhere SHALL be ignored.
REQ-025 In RUN, each tick cycle with no clear/load/pause SHALL decrement the time by exactly one second; ticks outside RUN SHALL have no effect.
REQ-026 Decrement borrow: sec>0 -> sec-1; sec==0 -> sec=59 and minute borrow; min==0 on borrow -> min=59 and hr-1.
REQ-027 When a decrement produces 00:00:00 the FSM SHALL enter EXPIRED at that same edge; running drops in the next cycle.
REQ-028 expired SHALL be high for exactly the one cycle spent in EXPIRED; EXPIRED SHALL go to IDLE at the next edge unless clear/load applies.
REQ-029 Counters SHALL never wrap below zero nor exceed HR_MAX:59:59; no decrement occurs from 00:00:00.
REQ-030 start and tick in the same ARMED cycle SHALL enter RUN without decrementing; the first decrement uses a later tick.
REQ-031 All outputs SHALL be registered; the first counter change after an accepted command appears one cycle after the command.

Reset
REQ-032 While rst is 0, outputs SHALL be hr/min/sec=0, running=0, expired=0, load_err=0, state IDLE, asynchronously.
REQ-033 After rst rises, the block SHALL ignore no inputs beyond the first clk edge; the first edge acts on sampled commands.
REQ-034 rst asserted mid-RUN SHALL abandon the countdown immediately, without an expired pulse.

Verification
REQ-035 Load 00:00:03, start, 3 ticks -> counters 2,1,0; expired high one cycle after the third tick edge; then IDLE.
REQ-036 Load 01:00:00, start, 1 tick -> 00:59:59; running stays 1.
REQ-037 Load 00:00:60 -> load_err one cycle, counters remain 00:00:00, state IDLE; load in RUN -> load_err, count unaffected.
REQ-038 RUN at 00:00:05, pause with tick same cycle -> 00:00:05 held, running=0; 4 ticks ignored; start, tick -> 00:00:04.
REQ-039 RUN at 00:10:00, clear+load+start same cycle -> 00:00:00, IDLE, no expired, no load_err.
REQ-040 rst low during RUN at 00:00:01 -> all outputs 0 asynchronously; no expired after rst release.
